// File: rtl/switch_pkg.sv
// Shared types and switch bit positions for the switch input path.
package switch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        VALID    = 2'd1,
        WAIT_REL = 2'd2
    } sw_state_t;

    localparam int unsigned SW_W     = 10;
    localparam int unsigned DATA_MSB = 7;
    localparam int unsigned STB_BIT  = 8;
    localparam int unsigned CLR_BIT  = 9;
    localparam int unsigned DATA_W   = DATA_MSB + 1;

endpackage : switch_pkg

// File: rtl/debounce.sv
// Single-bit synchroniser followed by a stable-level debouncer with a rise pulse.
module debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic nReset,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   din_sync;

    assign din_sync = sync_q[SYNC_STAGES-1];

    // Next-state: shift the synchroniser, count mismatching cycles, flip after a full stable run.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (din_sync != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = din_sync;
                rise_d  = din_sync;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule : debounce

// File: rtl/switch_handshake.sv
// Switch input path: synchronise switches, debounce the strobe, latch one word
// per press and offer it to the core under a valid/ack handshake.
module switch_handshake
    import switch_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic [SW_W-1:0]   SW,
    input  logic              ack,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              busy
);

    // Data bits plus the clear bit share one plain synchroniser chain.
    localparam int unsigned PSYNC_W = DATA_W + 1;

    logic [SYNC_STAGES-1:0][PSYNC_W-1:0] psync_q, psync_d;
    logic [PSYNC_W-1:0]                  sw_sync;
    logic [DATA_W-1:0]                   data_sync;
    logic                                clr;
    logic                                stb_db;
    logic                                stb_rise;

    sw_state_t         state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;

    debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_stb_db (
        .clk    (clk),
        .nReset (nReset),
        .din    (SW[STB_BIT]),
        .level  (stb_db),
        .rise   (stb_rise)
    );

    assign sw_sync   = psync_q[SYNC_STAGES-1];
    assign data_sync = sw_sync[DATA_MSB:0];
    assign clr       = sw_sync[PSYNC_W-1];

    // Shift data and clear bits through the synchroniser.
    always_comb begin
        psync_d = {psync_q[SYNC_STAGES-2:0], SW[CLR_BIT], SW[DATA_MSB:0]};
    end

    // Synchroniser registers.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            psync_q <= '0;
        end else begin
            psync_q <= psync_d;
        end
    end

    // Handshake next-state: clear wins, otherwise capture on press, release on ack.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (clr) begin
            state_d = IDLE;
            data_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (stb_rise) begin
                        data_d  = data_sync;
                        state_d = VALID;
                    end
                end
                VALID: begin
                    if (ack) begin
                        state_d = stb_db ? WAIT_REL : IDLE;
                    end
                end
                WAIT_REL: begin
                    if (!stb_db) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        valid_d = (state_d == VALID);
        busy_d  = (state_d != IDLE);
    end

    // Handshake state and registered outputs.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule : switch_handshake
